// File: rtl/data_structs.sv
// Shared geometry types: fixed-point coordinate width and the packed vec3/point layout.
// A vec3 packs as {x, y, z}, so x sits in the most significant coordinate slot.
package data_structs;

   localparam int COORD_W    = 28;
   localparam int COORD_FRAC = 16;

   typedef logic signed [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
      coord_t z;
   } vec3_t;

   typedef vec3_t point_t;

endpackage

// File: rtl/fxp_mac_rnd_sat.sv
// One axis of orig + round(t*dir >> FRAC): the multiply stage is registered on en_mul,
// and the round/add/saturate stage is registered on en_out.
module fxp_mac_rnd_sat #(
   parameter int WIDTH = 28,
   parameter int FRAC  = 16,
   parameter int SAT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_mul,
   input  logic             en_out,
   input  logic [WIDTH-1:0] orig,
   input  logic [WIDTH-1:0] dir,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] res,
   output logic             ovf
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = PW + 1;
   localparam logic signed [SW-1:0] HALF = {{(SW-1){1'b0}}, 1'b1} << (FRAC - 1);
   localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [PW-1:0] prod_d, prod_q;
   logic [WIDTH-1:0]     orig2_d, orig2_q;
   logic [WIDTH-1:0]     res_d, res_q;
   logic                 ovf_d, ovf_q;
   logic signed [SW-1:0] acc_s, shr_s, orig_ext_s, sum_s;
   logic                 ovf_s;

   always_comb begin
      prod_d  = prod_q;
      orig2_d = orig2_q;
      if (en_mul) begin
         prod_d  = $signed({{WIDTH{t[WIDTH-1]}}, t}) * $signed({{WIDTH{dir[WIDTH-1]}}, dir});
         orig2_d = orig;
      end else begin
         prod_d  = prod_q;
         orig2_d = orig2_q;
      end
   end

   // The shift is kept in its own all-signed expression so it stays arithmetic.
   always_comb begin
      acc_s      = $signed({prod_q[PW-1], prod_q}) + HALF;
      shr_s      = acc_s >>> FRAC;
      orig_ext_s = $signed({{(SW-WIDTH){orig2_q[WIDTH-1]}}, orig2_q});
      sum_s      = shr_s + orig_ext_s;
      ovf_s      = (sum_s > MAXV) || (sum_s < MINV);
      res_d      = res_q;
      ovf_d      = ovf_q;
      if (en_out) begin
         ovf_d = ovf_s;
         if (ovf_s && (SAT != 0)) begin
            res_d = (sum_s > MAXV) ? MAXV[WIDTH-1:0] : MINV[WIDTH-1:0];
         end else begin
            res_d = sum_s[WIDTH-1:0];
         end
      end else begin
         res_d = res_q;
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q  <= '0;
         orig2_q <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         prod_q  <= prod_d;
         orig2_q <= orig2_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   assign res = res_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/ray_at_pipe.sv
// Three-stage ray evaluator: point = orig + t*dir per axis, with a valid bit per stage
// and a single stall signal that freezes the whole pipe under output backpressure.
module ray_at_pipe
   import data_structs::*;
#(
   parameter int WIDTH = COORD_W,
   parameter int FRAC  = COORD_FRAC,
   parameter int SAT   = 1,
   parameter int TAG_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3*WIDTH-1:0] in_orig,
   input  logic [3*WIDTH-1:0] in_dir,
   input  logic [WIDTH-1:0]   in_t,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3*WIDTH-1:0] out_point,
   output logic [2:0]         out_ovf,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int VW = 3 * WIDTH;

   logic               advance_s, en_s2_s, en_s3_s;
   logic               v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
   logic [VW-1:0]      orig1_d, orig1_q, dir1_d, dir1_q;
   logic [WIDTH-1:0]   t1_d, t1_q;
   logic [TAG_W-1:0]   tag1_d, tag1_q, tag2_d, tag2_q, out_tag_d, out_tag_q;

   // Stalls only when the output holds an unaccepted result; no path from in_valid.
   assign advance_s = out_ready | ~out_valid_q;
   assign in_ready  = advance_s;
   assign en_s2_s   = advance_s & v1_q;
   assign en_s3_s   = advance_s & v2_q;

   always_comb begin
      v1_d    = v1_q;
      orig1_d = orig1_q;
      dir1_d  = dir1_q;
      t1_d    = t1_q;
      tag1_d  = tag1_q;
      if (advance_s && in_valid) begin
         v1_d    = 1'b1;
         orig1_d = in_orig;
         dir1_d  = in_dir;
         t1_d    = in_t;
         tag1_d  = in_tag;
      end else if (advance_s) begin
         v1_d = 1'b0;
      end else begin
         v1_d = v1_q;
      end
   end

   always_comb begin
      v2_d        = advance_s ? v1_q : v2_q;
      out_valid_d = advance_s ? v2_q : out_valid_q;
      tag2_d      = en_s2_s ? tag1_q : tag2_q;
      out_tag_d   = en_s3_s ? tag2_q : out_tag_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         orig1_q     <= '0;
         dir1_q      <= '0;
         t1_q        <= '0;
         tag1_q      <= '0;
         tag2_q      <= '0;
         out_tag_q   <= '0;
      end else begin
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         out_valid_q <= out_valid_d;
         orig1_q     <= orig1_d;
         dir1_q      <= dir1_d;
         t1_q        <= t1_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
         out_tag_q   <= out_tag_d;
      end
   end

   // Slice a=0 is z, a=2 is x, matching the {x,y,z} packing.
   for (genvar a = 0; a < 3; a++) begin : g_axis
      fxp_mac_rnd_sat #(
         .WIDTH(WIDTH),
         .FRAC (FRAC),
         .SAT  (SAT)
      ) u_mac (
         .clk   (clk),
         .rst_n (rst_n),
         .en_mul(en_s2_s),
         .en_out(en_s3_s),
         .orig  (orig1_q[a*WIDTH +: WIDTH]),
         .dir   (dir1_q[a*WIDTH +: WIDTH]),
         .t     (t1_q),
         .res   (out_point[a*WIDTH +: WIDTH]),
         .ovf   (out_ovf[a])
      );
   end

   assign out_valid = out_valid_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ray_at_pipe.sv
// Bench for ray_at_pipe: a saturating and a wrapping instance share stimulus and are
// checked against a plain-arithmetic model through an in-order scoreboard.
module tb_ray_at_pipe;

   localparam int W  = 28;
   localparam int F  = 16;
   localparam int TW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, out_ready;
   logic [3*W-1:0]  in_orig, in_dir;
   logic [W-1:0]    in_t;
   logic [TW-1:0]   in_tag;
   logic            in_ready_s, out_valid_s, in_ready_w, out_valid_w;
   logic [3*W-1:0]  out_point_s, out_point_w;
   logic [2:0]      out_ovf_s, out_ovf_w;
   logic [TW-1:0]   out_tag_s, out_tag_w;

   typedef struct packed {
      logic [3*W-1:0] ps;
      logic [2:0]     os;
      logic [3*W-1:0] pw;
      logic [2:0]     ow;
      logic [TW-1:0]  tag;
   } beat_t;

   typedef struct packed {
      logic [3*W-1:0] o;
      logic [3*W-1:0] d;
      logic [W-1:0]   t;
      logic [3*W-1:0] ps;
      logic [3*W-1:0] pw;
      logic [2:0]     ov;
   } vec_t;

   beat_t exp_q[$];
   beat_t got_q[$];
   int    n_pass  = 0;
   int    n_total = 0;

   always #5 clk = ~clk;

   ray_at_pipe #(.WIDTH(W), .FRAC(F), .SAT(1), .TAG_W(TW)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_orig(in_orig), .in_dir(in_dir), .in_t(in_t), .in_tag(in_tag),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_point(out_point_s),
      .out_ovf(out_ovf_s), .out_tag(out_tag_s)
   );

   ray_at_pipe #(.WIDTH(W), .FRAC(F), .SAT(0), .TAG_W(TW)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_orig(in_orig), .in_dir(in_dir), .in_t(in_t), .in_tag(in_tag),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_point(out_point_w),
      .out_ovf(out_ovf_w), .out_tag(out_tag_w)
   );

   // Exact integer arithmetic: floor((t*d + 2^(F-1)) / 2^F) + o, then range-check.
   function automatic logic [W:0] axis_ref(logic [W-1:0] o, logic [W-1:0] d,
                                           logic [W-1:0] t, bit sat);
      longint p, r, s, mx, mn;
      logic   ov;
      logic [W-1:0] res;
      p  = longint'($signed(t)) * longint'($signed(d));
      r  = (p + (64'sd1 <<< (F - 1))) >>> F;
      s  = longint'($signed(o)) + r;
      mx = (64'sd1 <<< (W - 1)) - 64'sd1;
      mn = -(64'sd1 <<< (W - 1));
      ov = (s > mx) || (s < mn);
      if (ov && sat) res = (s > mx) ? mx[W-1:0] : mn[W-1:0];
      else           res = s[W-1:0];
      return {ov, res};
   endfunction

   function automatic beat_t model(logic [3*W-1:0] o, logic [3*W-1:0] d,
                                   logic [W-1:0] t, logic [TW-1:0] tag);
      beat_t     b;
      logic [W:0] rs, rw;
      for (int a = 0; a < 3; a++) begin
         rs = axis_ref(o[a*W +: W], d[a*W +: W], t, 1'b1);
         rw = axis_ref(o[a*W +: W], d[a*W +: W], t, 1'b0);
         b.ps[a*W +: W] = rs[W-1:0];
         b.os[a]        = rs[W];
         b.pw[a*W +: W] = rw[W-1:0];
         b.ow[a]        = rw[W];
      end
      b.tag = tag;
      return b;
   endfunction

   function automatic logic [W-1:0] rnd_val();
      logic signed [19:0] sm;
      sm = 20'($urandom);
      case ($urandom_range(0, 3))
         0:       return W'($urandom);
         1:       return W'(sm);
         2:       return ($urandom_range(0, 1) != 0) ? 28'h0010000 : 28'hFFF0000;
         default: return ($urandom_range(0, 1) != 0) ? 28'h7FFFF00 + W'($urandom_range(0, 255))
                                                     : 28'h8000000 + W'($urandom_range(0, 255));
      endcase
   endfunction

   // Transfers are decided at the next rising edge from values that are stable here.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready_s) exp_q.push_back(model(in_orig, in_dir, in_t, in_tag));
         if (out_valid_s && out_ready)
            got_q.push_back({out_point_s, out_ovf_s, out_point_w, out_ovf_w, out_tag_s});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) tick();
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_orig   = '0;
      in_dir    = '0;
      in_t      = '0;
      in_tag    = '0;
      repeat (3) tick();
      n_total++;
      if ({out_valid_s, out_point_s, out_ovf_s, out_tag_s, out_valid_w, out_point_w} !== '0)
         $display("FAIL reset_outputs: got v=%0b pt=%h ovf=%b tag=%h, want all zero",
                  out_valid_s, out_point_s, out_ovf_s, out_tag_s);
      else n_pass++;
      n_total++;
      if (in_ready_s !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready_s);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      vec_t  tbl[8];
      beat_t got, want;
      tbl[0] = '{o: {28'h0010000, 28'h0020000, 28'h0030000}, d: {28'h0010000, 28'h0000000, 28'hFFF0000},
                 t: 28'h0020000, ps: {28'h0030000, 28'h0020000, 28'h0010000},
                 pw: {28'h0030000, 28'h0020000, 28'h0010000}, ov: 3'b000};
      tbl[1] = '{o: {28'h7FFFFFF, 28'h0, 28'h0}, d: {28'h0010000, 28'h0, 28'h0}, t: 28'h0010000,
                 ps: {28'h7FFFFFF, 28'h0, 28'h0}, pw: {28'h800FFFF, 28'h0, 28'h0}, ov: 3'b100};
      tbl[2] = '{o: {28'h0, 28'h8000000, 28'h0}, d: {28'h0, 28'hFFF0000, 28'h0}, t: 28'h0010000,
                 ps: {28'h0, 28'h8000000, 28'h0}, pw: {28'h0, 28'h7FF0000, 28'h0}, ov: 3'b010};
      tbl[3] = '{o: '0, d: {28'h0000001, 28'h0, 28'h0}, t: 28'h0008000,
                 ps: {28'h0000001, 28'h0, 28'h0}, pw: {28'h0000001, 28'h0, 28'h0}, ov: 3'b000};
      tbl[4] = '{o: '0, d: {28'h0000001, 28'h0, 28'h0}, t: 28'hFFF8000, ps: '0, pw: '0, ov: 3'b000};
      tbl[5] = '{o: '0, d: {28'hFFFFFFF, 28'h0, 28'h0}, t: 28'h0008000, ps: '0, pw: '0, ov: 3'b000};
      tbl[6] = '{o: '0, d: {28'h0000001, 28'h0, 28'h0}, t: 28'h0007FFF, ps: '0, pw: '0, ov: 3'b000};
      tbl[7] = '{o: {28'h0, 28'h0, 28'hFFF0000}, d: {28'h0, 28'h0, 28'h0018000}, t: 28'hFFE0000,
                 ps: {28'h0, 28'h0, 28'hFFC0000}, pw: {28'h0, 28'h0, 28'hFFC0000}, ov: 3'b000};
      settle();
      for (int k = 0; k < 11; k++) begin
         if (k < 8) begin
            in_valid = 1'b1;
            in_orig  = tbl[k].o;
            in_dir   = tbl[k].d;
            in_t     = tbl[k].t;
            in_tag   = 8'hA0 + 8'(k);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         n_total++;
         if (k < 3) begin
            if (out_valid_s !== 1'b0)
               $display("FAIL dir_latency k=%0d: out_valid got %b want 0", k, out_valid_s);
            else n_pass++;
         end else begin
            got  = {out_point_s, out_ovf_s, out_point_w, out_ovf_w, out_tag_s};
            want = {tbl[k-3].ps, tbl[k-3].ov, tbl[k-3].pw, tbl[k-3].ov, 8'hA0 + 8'(k - 3)};
            if (out_valid_s !== 1'b1 || got !== want)
               $display("FAIL dir_beat%0d: v=%b got %h want %h", k - 3, out_valid_s, got, want);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_random();
      int    acc = 0;
      int    cyc = 0;
      beat_t g, e;
      settle();
      in_orig = {rnd_val(), rnd_val(), rnd_val()};
      in_dir  = {rnd_val(), rnd_val(), rnd_val()};
      in_t    = rnd_val();
      in_tag  = 8'($urandom);
      while ((acc < 150 || exp_q.size() != got_q.size() || out_valid_s) && cyc < 2000) begin
         in_valid  = (acc < 150) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0) || (acc >= 150);
         #1;
         if (in_valid && in_ready_s) acc++;
         tick();
         if (in_valid && exp_q.size() > 0 && acc > 0) begin
            in_orig = {rnd_val(), rnd_val(), rnd_val()};
            in_dir  = {rnd_val(), rnd_val(), rnd_val()};
            in_t    = rnd_val();
            in_tag  = 8'($urandom);
         end
         cyc++;
      end
      n_total++;
      if (cyc >= 2000 || got_q.size() != 150)
         $display("FAIL rnd_count: got %0d results want 150 (cycles %0d)", got_q.size(), cyc);
      else n_pass++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_total++;
         if (g !== e) $display("FAIL rnd_beat: got %h want %h", g, e);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int             sent = 0;
      int             cyc  = 0;
      bit             have = 1'b0;
      logic [3*W-1:0] hp;
      logic [2:0]     ho;
      logic [TW-1:0]  ht;
      beat_t          g, e;
      settle();
      while ((sent < 10 || got_q.size() < 10 || out_valid_s) && cyc < 60) begin
         out_ready = !(cyc >= 5 && cyc < 10);
         in_valid  = (sent < 10);
         in_orig   = {rnd_val(), rnd_val(), rnd_val()};
         in_dir    = {rnd_val(), rnd_val(), rnd_val()};
         in_t      = rnd_val();
         in_tag    = 8'(sent);
         #1;
         if (!out_ready && out_valid_s) begin
            n_total++;
            if (in_ready_s !== 1'b0) $display("FAIL bp_in_ready cyc=%0d: got %b want 0", cyc, in_ready_s);
            else n_pass++;
            if (have) begin
               n_total++;
               if ({out_point_s, out_ovf_s, out_tag_s} !== {hp, ho, ht})
                  $display("FAIL bp_stable cyc=%0d: got %h want %h", cyc,
                           {out_point_s, out_ovf_s, out_tag_s}, {hp, ho, ht});
               else n_pass++;
            end else begin
               have = 1'b1;
               hp   = out_point_s;
               ho   = out_ovf_s;
               ht   = out_tag_s;
            end
         end
         if (in_valid && in_ready_s) sent++;
         tick();
         cyc++;
      end
      n_total++;
      if (got_q.size() != 10 || exp_q.size() != 10 || !have)
         $display("FAIL bp_count: got %0d results want 10 (stall seen %0b)", got_q.size(), have);
      else n_pass++;
      for (int k = 0; got_q.size() > 0 && exp_q.size() > 0; k++) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_total++;
         if (g !== e || g.tag !== 8'(k)) $display("FAIL bp_beat%0d: got %h want %h", k, g, e);
         else n_pass++;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      beat_t g;
      beat_t want;
      settle();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_orig  = {rnd_val(), rnd_val(), rnd_val()};
         in_dir   = {rnd_val(), rnd_val(), rnd_val()};
         in_t     = rnd_val();
         in_tag   = 8'h30 + 8'(k);
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      n_total++;
      if (out_valid_s !== 1'b0 || out_point_s !== '0 || out_tag_s !== '0 || out_ovf_s !== '0)
         $display("FAIL rstmid_async: v=%b pt=%h tag=%h ovf=%b want all zero",
                  out_valid_s, out_point_s, out_tag_s, out_ovf_s);
      else n_pass++;
      exp_q.delete();
      got_q.delete();
      tick();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_orig   = {28'h0010000, 28'h0000000, 28'h0000000};
      in_dir    = {28'h0010000, 28'h0010000, 28'h0010000};
      in_t      = 28'h0010000;
      in_tag    = 8'h77;
      want      = '{ps: {28'h0020000, 28'h0010000, 28'h0010000}, os: 3'b000,
                    pw: {28'h0020000, 28'h0010000, 28'h0010000}, ow: 3'b000, tag: 8'h77};
      for (int k = 1; k <= 5; k++) begin
         tick();
         in_valid = 1'b0;
         n_total++;
         if (k == 3) begin
            if (out_valid_s !== 1'b1 ||
                {out_point_s, out_ovf_s, out_point_w, out_ovf_w, out_tag_s} !== want)
               $display("FAIL rstmid_new: v=%b got %h want %h", out_valid_s,
                        {out_point_s, out_ovf_s, out_point_w, out_ovf_w, out_tag_s}, want);
            else n_pass++;
         end else begin
            if (out_valid_s !== 1'b0) $display("FAIL rstmid_stale edge%0d: out_valid got 1 want 0", k);
            else n_pass++;
         end
      end
      n_total++;
      if (got_q.size() != 1) $display("FAIL rstmid_count: got %0d results want 1", got_q.size());
      else begin
         g = got_q.pop_front();
         if (g !== want) $display("FAIL rstmid_count: got %h want %h", g, want);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ray_at_pipe.md
RAY_AT_PIPE -- requirements
Module: ray_at_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 28: signed two's-complement coordinate width.
REQ-002 SHALL have parameter FRAC, default 16: fractional bits of every coordinate and of t, with 1 <= FRAC < WIDTH.
REQ-003 SHALL have parameter SAT, default 1: 1 = saturate on overflow, 0 = wrap modulo 2^WIDTH.
REQ-004 SHALL have parameter TAG_W, default 8: sideband tag width.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1: input beat valid.
REQ-008 SHALL have port in_ready, output, 1: input beat accepted when high with in_valid.
REQ-009 SHALL have port in_orig, input, 3*WIDTH: ray origin {x,y,z}, x in the MSBs.
REQ-010 SHALL have port in_dir, input, 3*WIDTH: ray direction {x,y,z}.
REQ-011 SHALL have port in_t, input, WIDTH: signed ray parameter.
REQ-012 SHALL have port in_tag, input, TAG_W: opaque sideband, returned unchanged.
REQ-013 SHALL have port out_valid, output, 1: result valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port out_point, output, 3*WIDTH: orig + t*dir as {x,y,z}.
REQ-016 SHALL have port out_ovf, output, 3: per-axis overflow flag {x,y,z}.
REQ-017 SHALL have port out_tag, output, TAG_W: tag of this result.

Function
REQ-018 SHALL compute each axis as orig + round(t*dir >> FRAC) in Q(WIDTH-FRAC).FRAC.
REQ-019 SHALL form the full 2*WIDTH-bit signed product t*dir.
REQ-020 SHALL round by adding 2^(FRAC-1), then arithmetic-shifting right by FRAC.
REQ-021 SHALL add orig, sign-extended, at full width; no intermediate truncation.
REQ-022 SHALL, on an axis sum outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], set that axis's out_ovf bit.
REQ-023 SHALL, with SAT=1, clamp an overflowed axis to the nearest bound; with SAT=0, output the low WIDTH bits.
REQ-024 SHALL be a 3-stage pipeline: S1 input register, S2 multiply, S3 round/add/saturate.
REQ-025 SHALL give latency of exactly 3 clk edges from accepted input to out_valid when out_ready is held high.
REQ-026 SHALL sustain one result per cycle with out_ready held high.
REQ-027 SHALL advance all stages together on advance = out_ready | ~out_valid.
REQ-028 SHALL drive in_ready = advance, combinationally.
REQ-029 SHALL hold every stage, and out_point/out_ovf/out_tag stable, while out_valid=1 and out_ready=0.
REQ-030 SHALL carry a valid bit per stage; bubbles propagate as invalid beats and never produce out_valid.
REQ-031 SHALL not combinationally depend on in_valid for out_valid or in_ready.
REQ-032 SHALL treat a transfer as occurring only on a clk edge with valid & ready both high.

Reset
REQ-033 SHALL, on rst_n low, clear all stage valid bits immediately (asynchronous), with out_valid=0.
REQ-034 SHALL reset out_point=0, out_ovf=0, out_tag=0.
REQ-035 SHALL discard in-flight beats on reset mid-operation and emit nothing for them after release.
REQ-036 SHALL accept a new input on the first clk edge after rst_n deasserts if in_valid=1.

Structure
REQ-037 SHALL take the defaults WIDTH and FRAC from localparams COORD_W=28 and COORD_FRAC=16 added to the shared data_structs package.
REQ-038 SHALL pack ports so that, at WIDTH=28, they match the package vec3/point packing bit-for-bit.
REQ-039 SHALL implement the per-axis datapath as sub-module fxp_mac_rnd_sat (WIDTH/FRAC/SAT parameters), instantiated three times.

Verification (WIDTH=28, FRAC=16, 1.0=0x0010000)
REQ-040 SHALL cover: orig=(1,2,3), dir=(1,0,-1), t=2.0 -> out_point=(3,2,1) on the 3rd edge, out_ovf=0, tag echoed.
REQ-041 SHALL cover: SAT=1, orig.x=0x7FFFFFF, dir.x=1.0, t=1.0 -> out.x=0x7FFFFFF, out_ovf=3'b100.
REQ-042 SHALL cover: SAT=0, same stimulus as REQ-041 -> out.x=0x800FFFF, out_ovf=3'b100.
REQ-043 SHALL cover rounding: dir.x=0x0000001, t=0x0008000, orig=0 -> out.x=0x0000001; t=0xFFF8000 (-0.5) -> out.x=0.
REQ-044 SHALL cover backpressure: stream 10 tagged beats, out_ready low for 5 cycles mid-stream -> in_ready low after 3 held beats, outputs stable, all 10 delivered in order and none lost or duplicated.
REQ-045 SHALL cover reset mid-operation: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, no stale beat after release, next input emerges with latency 3.
